// File: rtl/iccm_port_arbiter_if.sv
// Request/grant and SRAM-side bundle for the ICCM port arbiter.
// The slave modport is the arbiter's view; master is the requesters-plus-SRAM side.
interface iccm_port_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 32
);
  logic          excl_b_i;

  logic          a_req_i;
  logic          a_gnt_o;
  logic          a_we_i;
  logic [AW-1:0] a_addr_i;
  logic [DW-1:0] a_wdata_i;
  logic [DW-1:0] a_wmask_i;
  logic [DW-1:0] a_rdata_o;
  logic          a_rvalid_o;

  logic          b_req_i;
  logic          b_gnt_o;
  logic          b_we_i;
  logic [AW-1:0] b_addr_i;
  logic [DW-1:0] b_wdata_i;
  logic [DW-1:0] b_wmask_i;
  logic [DW-1:0] b_rdata_o;
  logic          b_rvalid_o;

  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_wmask_o;
  logic [DW-1:0] mem_rdata_i;

  modport slave (
    input  excl_b_i,
    input  a_req_i, a_we_i, a_addr_i, a_wdata_i, a_wmask_i,
    output a_gnt_o, a_rdata_o, a_rvalid_o,
    input  b_req_i, b_we_i, b_addr_i, b_wdata_i, b_wmask_i,
    output b_gnt_o, b_rdata_o, b_rvalid_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    input  mem_rdata_i
  );

  modport master (
    output excl_b_i,
    output a_req_i, a_we_i, a_addr_i, a_wdata_i, a_wmask_i,
    input  a_gnt_o, a_rdata_o, a_rvalid_o,
    output b_req_i, b_we_i, b_addr_i, b_wdata_i, b_wmask_i,
    input  b_gnt_o, b_rdata_o, b_rvalid_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/iccm_port_arbiter.sv
// Single-port ICCM sharing between fetch (A, priority) and loader (B, starvation guard).
// Optional grant/conflict statistics are enabled with `define ICCM_ARB_STATS_EN.
module iccm_port_arbiter #(
  parameter int AW      = 12,
  parameter int DW      = 32,
  parameter int MaxWait = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  iccm_port_arbiter_if.slave   bus
`ifdef ICCM_ARB_STATS_EN
  ,
  output logic [15:0]          a_grant_cnt_o,
  output logic [15:0]          b_grant_cnt_o,
  output logic [15:0]          conflict_cnt_o
`endif
);

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] wmask;
  } sram_req_t;

  typedef enum logic {
    OwnA = 1'b0,
    OwnB = 1'b1
  } owner_e;

  typedef struct packed {
    logic   vld;
    owner_e own;
  } rtag_t;

  localparam logic [3:0] WaitMax = 4'(MaxWait);

  sram_req_t  a_req, b_req, mem_req;
  logic       a_gnt, b_gnt;
  logic [3:0] wait_cnt, wait_cnt_d;
  rtag_t      rtag_q, rtag_d;

  assign a_req = '{we: bus.a_we_i, addr: bus.a_addr_i, wdata: bus.a_wdata_i, wmask: bus.a_wmask_i};
  assign b_req = '{we: bus.b_we_i, addr: bus.b_addr_i, wdata: bus.b_wdata_i, wmask: bus.b_wmask_i};

  // Exclusive mode hands the macro to the loader; otherwise A wins unless B has starved.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (bus.excl_b_i) begin
      b_gnt = bus.b_req_i;
    end else if (bus.b_req_i && (wait_cnt == WaitMax)) begin
      b_gnt = 1'b1;
    end else if (bus.a_req_i) begin
      a_gnt = 1'b1;
    end else if (bus.b_req_i) begin
      b_gnt = 1'b1;
    end
  end

  always_comb begin
    mem_req = '0;
    if (a_gnt)      mem_req = a_req;
    else if (b_gnt) mem_req = b_req;
  end

  assign bus.a_gnt_o     = a_gnt;
  assign bus.b_gnt_o     = b_gnt;
  assign bus.mem_req_o   = a_gnt | b_gnt;
  assign bus.mem_we_o    = mem_req.we;
  assign bus.mem_addr_o  = mem_req.addr;
  assign bus.mem_wdata_o = mem_req.wdata;
  assign bus.mem_wmask_o = mem_req.wmask;

  always_comb begin
    wait_cnt_d = wait_cnt;
    if (!bus.b_req_i || b_gnt) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt != WaitMax) begin
      wait_cnt_d = wait_cnt + 4'd1;
    end
  end

  always_comb begin
    rtag_d     = '0;
    rtag_d.vld = (a_gnt | b_gnt) & ~mem_req.we;
    rtag_d.own = b_gnt ? OwnB : OwnA;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt <= 4'd0;
      rtag_q   <= '0;
    end else begin
      wait_cnt <= wait_cnt_d;
      rtag_q   <= rtag_d;
    end
  end

  // Read data is steered to the tagged owner only; everyone else sees zero.
  assign bus.a_rvalid_o = rtag_q.vld & (rtag_q.own == OwnA);
  assign bus.b_rvalid_o = rtag_q.vld & (rtag_q.own == OwnB);
  assign bus.a_rdata_o  = bus.a_rvalid_o ? bus.mem_rdata_i : '0;
  assign bus.b_rdata_o  = bus.b_rvalid_o ? bus.mem_rdata_i : '0;

`ifdef ICCM_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic en);
    return (en && (c != 16'hFFFF)) ? c + 16'd1 : c;
  endfunction

  logic conflict;
  assign conflict = bus.a_req_i & bus.b_req_i & ~bus.excl_b_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_grant_cnt_o  <= 16'd0;
      b_grant_cnt_o  <= 16'd0;
      conflict_cnt_o <= 16'd0;
    end else begin
      a_grant_cnt_o  <= sat_inc(a_grant_cnt_o, a_gnt);
      b_grant_cnt_o  <= sat_inc(b_grant_cnt_o, b_gnt);
      conflict_cnt_o <= sat_inc(conflict_cnt_o, conflict);
    end
  end
`endif

endmodule

// File: tb/tb_iccm_port_arbiter.sv
// Directed, table-driven bench for iccm_port_arbiter with a 1-cycle SRAM model.
module tb_iccm_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  iccm_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

`ifdef ICCM_ARB_STATS_EN
  logic [15:0] a_grant_cnt, b_grant_cnt, conflict_cnt;
`endif

  iccm_port_arbiter #(.AW(AW), .DW(DW), .MaxWait(4)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
`ifdef ICCM_ARB_STATS_EN
    ,
    .a_grant_cnt_o  (a_grant_cnt),
    .b_grant_cnt_o  (b_grant_cnt),
    .conflict_cnt_o (conflict_cnt)
`endif
  );

  // SRAM model: masked write, read data one cycle after a granted read
  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] rdata_q;
  assign bus.mem_rdata_i = rdata_q;
  always @(posedge clk_i) begin
    if (bus.mem_req_o) begin
      if (bus.mem_we_o)
        mem[bus.mem_addr_o] <= (mem[bus.mem_addr_o] & ~bus.mem_wmask_o) |
                               (bus.mem_wdata_o & bus.mem_wmask_o);
      else
        rdata_q <= mem[bus.mem_addr_o];
    end
  end

  typedef struct {
    logic          excl, a_req, a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic          b_req, b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          e_agnt, e_bgnt, e_mwe;
    logic [AW-1:0] e_maddr;
    logic [DW-1:0] e_mwdata;
    logic          e_arv;
    logic [DW-1:0] e_ard;
    logic          e_brv;
    logic [DW-1:0] e_brd;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs[23];

  function automatic vec_t mk(
    input logic excl, a_req, a_we, input logic [AW-1:0] a_addr, input logic [DW-1:0] a_wdata,
    input logic b_req, b_we, input logic [AW-1:0] b_addr, input logic [DW-1:0] b_wdata,
    input logic agnt, bgnt, mwe, input logic [AW-1:0] maddr, input logic [DW-1:0] mwdata,
    input logic arv, input logic [DW-1:0] ard, input logic brv, input logic [DW-1:0] brd);
    vec_t v;
    v.excl = excl; v.a_req = a_req; v.a_we = a_we; v.a_addr = a_addr; v.a_wdata = a_wdata;
    v.b_req = b_req; v.b_we = b_we; v.b_addr = b_addr; v.b_wdata = b_wdata;
    v.e_agnt = agnt; v.e_bgnt = bgnt; v.e_mwe = mwe; v.e_maddr = maddr; v.e_mwdata = mwdata;
    v.e_arv = arv; v.e_ard = ard; v.e_brv = brv; v.e_brd = brd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.excl_b_i  = v.excl;
    bus.a_req_i   = v.a_req;  bus.a_we_i = v.a_we; bus.a_addr_i = v.a_addr;
    bus.a_wdata_i = v.a_wdata; bus.a_wmask_i = 32'hFFFF_FFFF;
    bus.b_req_i   = v.b_req;  bus.b_we_i = v.b_we; bus.b_addr_i = v.b_addr;
    bus.b_wdata_i = v.b_wdata; bus.b_wmask_i = 32'hFFFF_FFFF;
  endtask

  task automatic set_req(input logic a, input logic b);
    bus.a_req_i = a; bus.a_we_i = 1'b0; bus.a_addr_i = 12'h010;
    bus.b_req_i = b; bus.b_we_i = 1'b0; bus.b_addr_i = 12'h020;
  endtask

  initial begin
    vec_t idle;
    logic [AW-1:0] z;
    z = '0;
    idle = mk(0,0,0,z,0, 0,0,z,0, 0,0,0,z,0, 0,0,0,0);
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA000_0000 | i;
    mem[12'h010] = 32'hDEAD_BEEF;
    rdata_q = '0;

    vecs[0]  = idle;
    vecs[1]  = mk(0,1,0,12'h010,0, 0,0,z,0, 1,0,0,12'h010,0, 0,0,0,0);
    vecs[2]  = mk(0,0,0,z,0, 0,0,z,0, 0,0,0,z,0, 1,32'hDEAD_BEEF,0,0);
    vecs[3]  = mk(0,0,0,z,0, 1,0,12'h020,0, 0,1,0,12'h020,0, 0,0,0,0);
    vecs[4]  = mk(0,1,0,12'h030,0, 0,0,z,0, 1,0,0,12'h030,0, 0,0,1,32'hA000_0020);
    vecs[5]  = mk(0,1,0,12'h041,0, 1,0,12'h051,0, 1,0,0,12'h041,0, 1,32'hA000_0030,0,0);
    for (int i = 6; i <= 8; i++)
      vecs[i] = mk(0,1,0,12'h041,0, 1,0,12'h051,0, 1,0,0,12'h041,0, 1,32'hA000_0041,0,0);
    vecs[9]  = mk(0,1,0,12'h041,0, 1,0,12'h051,0, 0,1,0,12'h051,0, 1,32'hA000_0041,0,0);
    vecs[10] = mk(0,1,0,12'h041,0, 1,0,12'h051,0, 1,0,0,12'h041,0, 0,0,1,32'hA000_0051);
    vecs[11] = mk(0,0,0,z,0, 0,0,z,0, 0,0,0,z,0, 1,32'hA000_0041,0,0);
    vecs[12] = mk(1,1,0,12'h060,0, 1,1,12'h3FF,32'h1234_5678, 0,1,1,12'h3FF,32'h1234_5678, 0,0,0,0);
    vecs[13] = mk(1,1,0,12'h060,0, 0,0,z,0, 0,0,0,z,0, 0,0,0,0);
    vecs[14] = mk(0,1,0,12'h3FF,0, 0,0,z,0, 1,0,0,12'h3FF,0, 0,0,0,0);
    vecs[15] = mk(0,0,0,z,0, 0,0,z,0, 0,0,0,z,0, 1,32'h1234_5678,0,0);
    vecs[16] = mk(0,1,0,12'h070,0, 0,0,z,0, 1,0,0,12'h070,0, 0,0,0,0);
    vecs[17] = mk(1,1,0,12'h070,0, 0,0,z,0, 0,0,0,z,0, 1,32'hA000_0070,0,0);
    vecs[18] = mk(1,0,0,z,0, 1,0,12'h080,0, 0,1,0,12'h080,0, 0,0,0,0);
    vecs[19] = mk(0,0,0,z,0, 0,0,z,0, 0,0,0,z,0, 0,0,1,32'hA000_0080);
    vecs[20] = mk(0,1,1,12'h090,32'hCAFE_F00D, 0,0,z,0, 1,0,1,12'h090,32'hCAFE_F00D, 0,0,0,0);
    vecs[21] = mk(0,1,0,12'h090,0, 0,0,z,0, 1,0,0,12'h090,0, 0,0,0,0);
    vecs[22] = mk(0,0,0,z,0, 0,0,z,0, 0,0,0,z,0, 1,32'hCAFE_F00D,0,0);

    // Reset: registers clear, grants still follow the request combinationally
    rst_ni = 1'b0;
    drive(idle);
    bus.a_req_i = 1'b1; bus.a_addr_i = 12'h005;
    repeat (2) @(negedge clk_i);
    #1;
    chk("reset_state",
        {bus.a_rvalid_o, bus.b_rvalid_o, dut.wait_cnt, bus.a_gnt_o, bus.mem_addr_o},
        {1'b0, 1'b0, 4'd0, 1'b1, 12'h005});
    bus.a_req_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 23; i++) begin
      @(negedge clk_i);
      drive(vecs[i]);
      #1;
      chk($sformatf("vec%0d", i),
          {bus.a_gnt_o, bus.b_gnt_o, bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o,
           bus.mem_wdata_o, bus.mem_wmask_o, bus.a_rvalid_o, bus.a_rdata_o,
           bus.b_rvalid_o, bus.b_rdata_o},
          {vecs[i].e_agnt, vecs[i].e_bgnt, vecs[i].e_agnt | vecs[i].e_bgnt, vecs[i].e_mwe,
           vecs[i].e_maddr, vecs[i].e_mwdata,
           (vecs[i].e_agnt | vecs[i].e_bgnt) ? 32'hFFFF_FFFF : 32'h0,
           vecs[i].e_arv, vecs[i].e_ard, vecs[i].e_brv, vecs[i].e_brd});
    end

    // Reset held across the edge of a granted read: its rvalid must never appear
    @(negedge clk_i); drive(idle); set_req(1'b1, 1'b1);
    @(negedge clk_i);
    @(negedge clk_i);
    #1 chk("pre_reset_gnt", {bus.a_gnt_o, bus.a_rvalid_o}, {1'b1, 1'b1});
    #1 rst_ni = 1'b0;
    @(posedge clk_i);
    #2 set_req(1'b0, 1'b0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    #1;
    chk("reset_drop_rvalid", {bus.a_rvalid_o, bus.b_rvalid_o}, {1'b0, 1'b0});
    chk("reset_wait_cnt", dut.wait_cnt, 4'd0);

`ifdef ICCM_ARB_STATS_EN
    @(negedge clk_i); set_req(1'b1, 1'b1);
    repeat (10) @(negedge clk_i);
    #1;
    chk("conflict_cnt", conflict_cnt, 16'd10);
    chk("a_grant_cnt", a_grant_cnt, 16'd8);
    chk("b_grant_cnt", b_grant_cnt, 16'd2);
    set_req(1'b0, 1'b0);
`endif

    @(negedge clk_i);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
